// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/status bundle between the multi-cycle control FSM and the shared datapath.
// The FSM sits on the master modport; the datapath and memory side use the slave modport.
interface multicycle_ctrl_fsm_if #(
  parameter int unsigned CNT_W = 32
);
  // Datapath / memory status into the FSM
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             alu_zero;
  logic             alu_lt;
  logic             alu_ltu;
  logic             mem_ready;

  // Control out of the FSM
  logic             mem_req;
  logic             mem_we;
  logic             adr_src;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       result_src;
  logic [2:0]       imm_src;
  logic [1:0]       alu_op;
  logic             is_imm;
  logic [3:0]       state_o;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct3, alu_zero, alu_lt, alu_ltu, mem_ready,
    output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
    output alu_src_a, alu_src_b, result_src, imm_src, alu_op, is_imm,
    output state_o, halted, illegal, retired
  );

  modport slave (
    output opcode, funct3, alu_zero, alu_lt, alu_ltu, mem_ready,
    input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
    input  alu_src_a, alu_src_b, result_src, imm_src, alu_op, is_imm,
    input  state_o, halted, illegal, retired
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute/memory/writeback
// over the shared datapath, counts retired instructions and traps on illegal opcodes.
module multicycle_ctrl_fsm #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_ctrl_fsm_if.master  io_ctrl
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9,
    StJal    = 4'd10,
    StJalr   = 4'd11,
    StExecU  = 4'd12,
    StHalt   = 4'd13,
    StTrap   = 4'd14
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_retired;
  logic             r_halted;
  logic             r_illegal;
  logic             w_taken;
  logic             w_retire;

  // Branch condition evaluated from the SUB flags of the current cycle
  always_comb begin
    w_taken = 1'b0;
    unique case (io_ctrl.funct3)
      3'b000:  w_taken = io_ctrl.alu_zero;
      3'b001:  w_taken = ~io_ctrl.alu_zero;
      3'b100:  w_taken = io_ctrl.alu_lt;
      3'b101:  w_taken = ~io_ctrl.alu_lt;
      3'b110:  w_taken = io_ctrl.alu_ltu;
      3'b111:  w_taken = ~io_ctrl.alu_ltu;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_retire = (r_state != StFetch) && (w_state_nxt == StFetch);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StFetch;
      r_retired <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
      end
      // Set together with the state change so the flags line up with state_o
      if (w_state_nxt == StHalt || w_state_nxt == StTrap) begin
        r_halted <= 1'b1;
      end
      if (w_state_nxt == StTrap) begin
        r_illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StFetch: begin
        if (io_ctrl.mem_ready) begin
          w_state_nxt = StDecode;
        end
      end
      StDecode: begin
        unique case (io_ctrl.opcode)
          OpLoad, OpStore: w_state_nxt = StMemAdr;
          OpReg:           w_state_nxt = StExecR;
          OpImm:           w_state_nxt = StExecI;
          OpBranch:        w_state_nxt = StBranch;
          OpJal:           w_state_nxt = StJal;
          OpJalr:          w_state_nxt = StJalr;
          OpLui, OpAuipc:  w_state_nxt = StExecU;
          OpSystem:        w_state_nxt = StHalt;
          default:         w_state_nxt = StTrap;
        endcase
      end
      StMemAdr: w_state_nxt = io_ctrl.opcode[5] ? StMemWr : StMemRd;
      StMemRd: begin
        if (io_ctrl.mem_ready) begin
          w_state_nxt = StMemWb;
        end
      end
      StMemWb: w_state_nxt = StFetch;
      StMemWr: begin
        if (io_ctrl.mem_ready) begin
          w_state_nxt = StFetch;
        end
      end
      StExecR, StExecI, StExecU: w_state_nxt = StAluWb;
      StAluWb: w_state_nxt = StFetch;
      // funct3 010/011 are not branch encodings
      StBranch: w_state_nxt = (io_ctrl.funct3[2:1] == 2'b01) ? StTrap : StFetch;
      StJal:    w_state_nxt = StAluWb;
      // JALR leaves its target in ALUOut, then shares the JAL commit cycle
      StJalr:   w_state_nxt = StJal;
      StHalt:   w_state_nxt = StHalt;
      StTrap:   w_state_nxt = StTrap;
      default:  w_state_nxt = StTrap;
    endcase
  end

  always_comb begin
    io_ctrl.mem_req    = 1'b0;
    io_ctrl.mem_we     = 1'b0;
    io_ctrl.adr_src    = 1'b0;
    io_ctrl.ir_write   = 1'b0;
    io_ctrl.pc_write   = 1'b0;
    io_ctrl.reg_write  = 1'b0;
    io_ctrl.alu_src_a  = 2'b00;
    io_ctrl.alu_src_b  = 2'b00;
    io_ctrl.result_src = 2'b00;
    io_ctrl.alu_op     = 2'b00;
    io_ctrl.is_imm     = 1'b0;
    unique case (r_state)
      StFetch: begin
        io_ctrl.mem_req = 1'b1;
        if (io_ctrl.mem_ready) begin
          io_ctrl.ir_write   = 1'b1;
          io_ctrl.pc_write   = 1'b1;
          io_ctrl.alu_src_b  = 2'b10;
          io_ctrl.result_src = 2'b10;
        end
      end
      StDecode: begin
        io_ctrl.alu_src_a = 2'b01;
        io_ctrl.alu_src_b = 2'b01;
      end
      StMemAdr: begin
        io_ctrl.alu_src_a = 2'b10;
        io_ctrl.alu_src_b = 2'b01;
      end
      StMemRd: begin
        io_ctrl.mem_req = 1'b1;
        io_ctrl.adr_src = 1'b1;
      end
      StMemWb: begin
        io_ctrl.result_src = 2'b01;
        io_ctrl.reg_write  = 1'b1;
      end
      StMemWr: begin
        io_ctrl.mem_req = 1'b1;
        io_ctrl.mem_we  = 1'b1;
        io_ctrl.adr_src = 1'b1;
      end
      StExecR: begin
        io_ctrl.alu_src_a = 2'b10;
        io_ctrl.alu_op    = 2'b10;
      end
      StExecI: begin
        io_ctrl.alu_src_a = 2'b10;
        io_ctrl.alu_src_b = 2'b01;
        io_ctrl.alu_op    = 2'b11;
        io_ctrl.is_imm    = 1'b1;
      end
      StAluWb: io_ctrl.reg_write = 1'b1;
      StBranch: begin
        io_ctrl.alu_src_a = 2'b10;
        io_ctrl.alu_op    = 2'b01;
        io_ctrl.pc_write  = w_taken;
      end
      StJal: begin
        io_ctrl.alu_src_a = 2'b01;
        io_ctrl.alu_src_b = 2'b10;
        io_ctrl.pc_write  = 1'b1;
      end
      StJalr: begin
        io_ctrl.alu_src_a = 2'b10;
        io_ctrl.alu_src_b = 2'b01;
      end
      StExecU: begin
        // LUI keeps A at 00; the datapath zeroes that operand for LUI
        io_ctrl.alu_src_a = io_ctrl.opcode[5] ? 2'b00 : 2'b01;
        io_ctrl.alu_src_b = 2'b01;
      end
      StHalt, StTrap: ;
      default: ;
    endcase
  end

  always_comb begin
    io_ctrl.imm_src = 3'b000;
    unique case (io_ctrl.opcode)
      OpStore:        io_ctrl.imm_src = 3'b001;
      OpBranch:       io_ctrl.imm_src = 3'b010;
      OpLui, OpAuipc: io_ctrl.imm_src = 3'b011;
      OpJal:          io_ctrl.imm_src = 3'b100;
      default:        io_ctrl.imm_src = 3'b000;
    endcase
  end

  assign io_ctrl.state_o = r_state;
  assign io_ctrl.halted  = r_halted;
  assign io_ctrl.illegal = r_illegal;
  assign io_ctrl.retired = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: per-cycle expected outputs are queued when an
// instruction is scheduled and popped/compared against the DUT each cycle.
module tb_multicycle_ctrl_fsm;

  logic clk;
  logic rst_n;

  multicycle_ctrl_fsm_if #(.CNT_W(32)) bus ();

  multicycle_ctrl_fsm #(.CNT_W(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_ctrl (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rs;
    logic [1:0] op;
    logic       is_imm;
    logic [2:0] imm;
    logic       halted;
    logic       illegal;
  } out_t;

  typedef struct {
    out_t        o;
    logic        rdy;
    logic [31:0] ret;
  } rec_t;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        z;
    logic        lt;
    logic        ltu;
    int          len;
    logic [23:0] seq;  // first state in the top nibble
  } vec_t;

  rec_t        q[$];
  vec_t        vecs[15];
  int          errors;
  int          checks;
  int          step;
  logic [31:0] exp_retired;

  function automatic logic br_taken(logic [2:0] f3, logic z, logic lt, logic ltu);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(logic [6:0] opc);
    case (opc)
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b0110111, 7'b0010111: return 3'b011;
      7'b1101111:             return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic out_t model(logic [3:0] st, logic [6:0] opc, logic [2:0] f3, logic z,
                                 logic lt, logic ltu, logic rdy);
    out_t o;
    o     = '0;
    o.st  = st;
    o.imm = imm_of(opc);
    case (st)
      4'd0: begin
        o.mem_req = 1'b1;
        if (rdy) begin
          o.ir_write = 1'b1; o.pc_write = 1'b1; o.b = 2'b10; o.rs = 2'b10;
        end
      end
      4'd1:  begin o.a = 2'b01; o.b = 2'b01; end
      4'd2:  begin o.a = 2'b10; o.b = 2'b01; end
      4'd3:  begin o.mem_req = 1'b1; o.adr_src = 1'b1; end
      4'd4:  begin o.rs = 2'b01; o.reg_write = 1'b1; end
      4'd5:  begin o.mem_req = 1'b1; o.mem_we = 1'b1; o.adr_src = 1'b1; end
      4'd6:  begin o.a = 2'b10; o.op = 2'b10; end
      4'd7:  begin o.a = 2'b10; o.b = 2'b01; o.op = 2'b11; o.is_imm = 1'b1; end
      4'd8:  o.reg_write = 1'b1;
      4'd9:  begin o.a = 2'b10; o.op = 2'b01; o.pc_write = br_taken(f3, z, lt, ltu); end
      4'd10: begin o.a = 2'b01; o.b = 2'b10; o.pc_write = 1'b1; end
      4'd11: begin o.a = 2'b10; o.b = 2'b01; end
      4'd12: begin o.b = 2'b01; o.a = opc[5] ? 2'b00 : 2'b01; end
      4'd13: o.halted = 1'b1;
      4'd14: begin o.halted = 1'b1; o.illegal = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic set_instr(logic [6:0] opc, logic [2:0] f3, logic z, logic lt, logic ltu);
    bus.opcode   = opc;
    bus.funct3   = f3;
    bus.alu_zero = z;
    bus.alu_lt   = lt;
    bus.alu_ltu  = ltu;
  endtask

  task automatic push(logic [3:0] st, logic rdy);
    rec_t r;
    r.o   = model(st, bus.opcode, bus.funct3, bus.alu_zero, bus.alu_lt, bus.alu_ltu, rdy);
    r.rdy = rdy;
    r.ret = exp_retired;
    q.push_back(r);
  endtask

  task automatic run_queue();
    rec_t r;
    out_t got;
    while (q.size() > 0) begin
      @(negedge clk);
      r = q.pop_front();
      bus.mem_ready = r.rdy;
      #1;
      got = {bus.state_o, bus.mem_req, bus.mem_we, bus.adr_src, bus.ir_write, bus.pc_write,
             bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.alu_op,
             bus.is_imm, bus.imm_src, bus.halted, bus.illegal};
      checks++;
      if (got !== r.o) begin
        errors++;
        $display("FAIL outs step=%0d state=%0d got=%h exp=%h", step, r.o.st, got, r.o);
      end
      checks++;
      if (bus.retired !== r.ret) begin
        errors++;
        $display("FAIL retired step=%0d got=%0d exp=%0d", step, bus.retired, r.ret);
      end
      step++;
    end
  endtask

  task automatic do_reset();
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_retired = '0;
    push(4'd0, 1'b0);
    run_queue();
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    step        = 0;
    exp_retired = '0;
    rst_n       = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
    bus.mem_ready = 1'b0;

    vecs[0]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 4, 24'h016800}; // ADD
    vecs[1]  = '{7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0, 4, 24'h017800}; // ADDI
    vecs[2]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 5, 24'h012340}; // LW
    vecs[3]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 4, 24'h012500}; // SW
    vecs[4]  = '{7'b1100011, 3'b000, 1'b1, 1'b0, 1'b0, 3, 24'h019000}; // BEQ taken
    vecs[5]  = '{7'b1100011, 3'b001, 1'b1, 1'b0, 1'b0, 3, 24'h019000}; // BNE not taken
    vecs[6]  = '{7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 3, 24'h019000}; // BNE taken
    vecs[7]  = '{7'b1100011, 3'b100, 1'b0, 1'b1, 1'b0, 3, 24'h019000}; // BLT taken
    vecs[8]  = '{7'b1100011, 3'b111, 1'b0, 1'b0, 1'b1, 3, 24'h019000}; // BGEU not taken
    vecs[9]  = '{7'b1100011, 3'b101, 1'b0, 1'b0, 1'b0, 3, 24'h019000}; // BGE taken
    vecs[10] = '{7'b1100011, 3'b110, 1'b0, 1'b0, 1'b0, 3, 24'h019000}; // BLTU not taken
    vecs[11] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 4, 24'h01A800}; // JAL
    vecs[12] = '{7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 5, 24'h01BA80}; // JALR
    vecs[13] = '{7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 4, 24'h01C800}; // LUI
    vecs[14] = '{7'b0010111, 3'b000, 1'b0, 1'b0, 1'b0, 4, 24'h01C800}; // AUIPC

    // Power-up reset, then one stalled fetch cycle
    do_reset();

    foreach (vecs[k]) begin
      set_instr(vecs[k].opc, vecs[k].f3, vecs[k].z, vecs[k].lt, vecs[k].ltu);
      for (int i = 0; i < vecs[k].len; i++) push(vecs[k].seq[20-4*i +: 4], 1'b1);
      run_queue();
      exp_retired = exp_retired + 1;
    end

    // Fetch stall, then LW with MEM_RD stalled for three cycles
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
    push(4'd0, 1'b0); push(4'd0, 1'b0); push(4'd0, 1'b1);
    push(4'd1, 1'b1); push(4'd2, 1'b1);
    push(4'd3, 1'b0); push(4'd3, 1'b0); push(4'd3, 1'b0); push(4'd3, 1'b1);
    push(4'd4, 1'b1);
    run_queue();
    exp_retired = exp_retired + 1;

    // SW with a stalled write
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
    push(4'd0, 1'b1); push(4'd1, 1'b1); push(4'd2, 1'b1);
    push(4'd5, 1'b0); push(4'd5, 1'b1);
    run_queue();
    exp_retired = exp_retired + 1;

    // Reset in the middle of a MEM_RD stall abandons the request
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
    push(4'd0, 1'b1); push(4'd1, 1'b1); push(4'd2, 1'b1);
    push(4'd3, 1'b0); push(4'd3, 1'b0);
    run_queue();
    do_reset();

    // ECALL halts without retiring; mem_ready pulses are ignored
    set_instr(7'b1110011, 3'b000, 1'b0, 1'b0, 1'b0);
    push(4'd0, 1'b1); push(4'd1, 1'b1);
    push(4'd13, 1'b1); push(4'd13, 1'b0); push(4'd13, 1'b1); push(4'd13, 1'b1);
    run_queue();
    do_reset();

    // Illegal opcode traps
    set_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0);
    push(4'd0, 1'b1); push(4'd1, 1'b1);
    push(4'd14, 1'b1); push(4'd14, 1'b0); push(4'd14, 1'b1);
    run_queue();
    do_reset();

    // One good ADD, then a branch with funct3=010 traps after BRANCH
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
    push(4'd0, 1'b1); push(4'd1, 1'b1); push(4'd6, 1'b1); push(4'd8, 1'b1);
    run_queue();
    exp_retired = exp_retired + 1;
    set_instr(7'b1100011, 3'b010, 1'b0, 1'b0, 1'b0);
    push(4'd0, 1'b1); push(4'd1, 1'b1); push(4'd9, 1'b1);
    push(4'd14, 1'b1); push(4'd14, 1'b1);
    run_queue();
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
